// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module : seg_pkg
// Brief  : Display codes, seven-segment glyphs and segment bit order shared
//          by the scan driver and its encoder.
// Rev    : 1.0
// ============================================================================
package seg_pkg;

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_A     = 4'd12;
    localparam logic [3:0] CODE_P     = 4'd13;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    // Segment bus order {a,b,c,d,e,f,g}: a is the MSB
    localparam int SEG_BIT_A = 6;
    localparam int SEG_BIT_B = 5;
    localparam int SEG_BIT_C = 4;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 2;
    localparam int SEG_BIT_F = 1;
    localparam int SEG_BIT_G = 0;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_A    = 7'b1110111;
    localparam logic [6:0] SEG_P    = 7'b1100111;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bch2disp.sv
`default_nettype none
// ============================================================================
// Module : bch2disp
// Brief  : Combinational 4-bit display code to seven-segment glyph encoder.
// Rev    : 1.0
// ============================================================================
module bch2disp
    import seg_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_code)
            4'd0:      o_seg = SEG_0;
            4'd1:      o_seg = SEG_1;
            4'd2:      o_seg = SEG_2;
            4'd3:      o_seg = SEG_3;
            4'd4:      o_seg = SEG_4;
            4'd5:      o_seg = SEG_5;
            4'd6:      o_seg = SEG_6;
            4'd7:      o_seg = SEG_7;
            4'd8:      o_seg = SEG_8;
            4'd9:      o_seg = SEG_9;
            CODE_DASH: o_seg = SEG_DASH;
            CODE_A:    o_seg = SEG_A;
            CODE_P:    o_seg = SEG_P;
            default:   o_seg = SEG_OFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module : seg_scan_driver
// Brief  : Time-multiplexed seven-segment driver with frame snapshotting,
//          per-digit blink and hour-tens leading-zero blanking.
// Rev    : 1.0
// ============================================================================
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIG        = 6,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4*N_DIG-1:0] digits_in,
    input  logic [N_DIG-1:0]   blink_mask,
    input  logic               blank_lz,
    output logic [6:0]         seg,
    output logic [N_DIG-1:0]   dig_en,
    output logic               frame_start
);

    localparam int DIV_W = cnt_width(SCAN_DIV);
    localparam int IDX_W = cnt_width(N_DIG);
    localparam int FRM_W = cnt_width(BLINK_FRAMES);

    localparam logic [DIV_W-1:0] c_div_last = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(N_DIG - 1);
    localparam logic [FRM_W-1:0] c_frm_last = FRM_W'(BLINK_FRAMES - 1);

    logic [DIV_W-1:0]   r_div;
    logic [IDX_W-1:0]   r_idx;
    logic [FRM_W-1:0]   r_frm;
    logic               r_phase;
    logic [4*N_DIG-1:0] r_codes;
    logic [N_DIG-1:0]   r_mask;
    logic               r_lz;

    logic               w_div_wrap;
    logic               w_idx_wrap;
    logic               w_frm_wrap;
    logic               w_snap;
    logic               w_guard;
    logic [3:0]         w_code;
    logic [6:0]         w_glyph;
    logic [N_DIG-1:0]   w_onehot;
    logic               w_blink_bit;
    logic               w_force_off;

    assign w_div_wrap = (r_div == c_div_last);
    assign w_idx_wrap = (r_idx == c_idx_last);
    assign w_frm_wrap = (r_frm == c_frm_last);
    assign w_snap     = (r_div == '0) && (r_idx == '0);
    assign w_guard    = (r_div == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div   <= '0;
            r_idx   <= '0;
            r_frm   <= '0;
            r_phase <= 1'b1;
        end else begin
            r_div <= w_div_wrap ? '0 : r_div + 1'b1;
            if (w_div_wrap) begin
                r_idx <= w_idx_wrap ? '0 : r_idx + 1'b1;
                if (w_idx_wrap) begin
                    r_frm <= w_frm_wrap ? '0 : r_frm + 1'b1;
                    if (w_frm_wrap) begin
                        r_phase <= ~r_phase;
                    end
                end
            end
        end
    end

    // Inputs are only ever observed here so a digit cannot tear mid-frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_codes <= {N_DIG{CODE_BLANK}};
            r_mask  <= '0;
            r_lz    <= 1'b0;
        end else if (w_snap) begin
            r_codes <= digits_in;
            r_mask  <= blink_mask;
            r_lz    <= blank_lz;
        end
    end

    always_comb begin
        w_code = CODE_BLANK;
        for (int i = 0; i < N_DIG; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_code = r_codes[4*i +: 4];
            end
        end
    end

    assign w_onehot    = N_DIG'(1) << r_idx;
    assign w_blink_bit = |(r_mask & w_onehot);
    assign w_force_off = w_guard
                       || (w_blink_bit && !r_phase)
                       || (r_lz && (r_idx == c_idx_last) && (w_code == 4'd0));

    bch2disp u_enc (
        .i_code (w_code),
        .o_seg  (w_glyph)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= SEG_OFF;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            seg         <= w_force_off ? SEG_OFF : w_glyph;
            dig_en      <= w_guard ? '0 : w_onehot;
            frame_start <= w_snap;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module : tb_seg_scan_driver
// Brief  : Self-checking bench for seg_scan_driver against an elapsed-time model.
// Rev    : 1.0
// ============================================================================
module tb_seg_scan_driver;

    localparam int N  = 6;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FR = N * SD;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [4*N-1:0] digits_in = '0;
    logic [N-1:0]   blink_mask = '0;
    logic           blank_lz = 1'b0;
    logic [6:0]     seg;
    logic [N-1:0]   dig_en;
    logic           frame_start;

    int checks = 0;
    int failures = 0;

    seg_scan_driver #(
        .N_DIG        (N),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .digits_in   (digits_in),
        .blink_mask  (blink_mask),
        .blank_lz    (blank_lz),
        .seg         (seg),
        .dig_en      (dig_en),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] glyph(input int c);
        case (c)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            10: return 7'b0000001;
            12: return 7'b1110111;
            13: return 7'b1100111;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: outputs after the k-th edge since release follow from p=k-1
    int unsigned    n_edge = 0;
    logic [4*N-1:0] m_codes = '0;
    logic [N-1:0]   m_mask = '0;
    logic           m_lz = 1'b0;
    logic [6:0]     exp_seg = '0;
    logic [N-1:0]   exp_en = '0;
    logic           exp_fs = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_edge  = 0;
            exp_seg = '0;
            exp_en  = '0;
            exp_fs  = 1'b0;
        end else begin
            int p, d, ix, fr, code;
            bit vis;
            p  = int'(n_edge);
            d  = p % SD;
            ix = (p / SD) % N;
            fr = p / FR;
            if (p % FR == 0) begin
                m_codes = digits_in;
                m_mask  = blink_mask;
                m_lz    = blank_lz;
            end
            exp_fs = (p % FR == 0);
            if (d == 0) begin
                exp_seg = '0;
                exp_en  = '0;
            end else begin
                code = int'(m_codes[ix*4 +: 4]);
                vis  = !(m_mask[ix] && ((fr / BF) % 2 == 1))
                    && !(m_lz && ix == N-1 && code == 0);
                exp_seg = vis ? glyph(code) : 7'b0;
                exp_en  = N'(1) << ix;
            end
            n_edge++;
        end
    end

    always @(negedge clk) begin
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("dig_en", 32'(dig_en), 32'(exp_en));
        chk("frame_start", 32'(frame_start), 32'(exp_fs));
    end

    // Leaves the bench at the negedge where frame_start is seen (frame offset 0)
    task automatic wait_fs();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_start && k < 100);
        checks++;
        if (!frame_start) begin
            failures++;
            $display("FAIL wait_frame_start actual=timeout required=pulse");
        end
    endtask

    initial begin
        digits_in  = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        blink_mask = '0;
        blank_lz   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_seg", 32'(seg), 32'd0);
        chk("reset_dig_en", 32'(dig_en), 32'd0);
        rst_n = 1'b1;

        @(negedge clk);
        chk("first_fs", 32'(frame_start), 32'd1);
        chk("first_guard", 32'(dig_en), 32'd0);
        @(negedge clk);
        chk("idx0_en", 32'(dig_en), 32'b000001);
        chk("idx0_seg", 32'(seg), 32'b1011111);
        repeat (20) @(negedge clk);
        chk("idx5_en", 32'(dig_en), 32'b100000);
        chk("idx5_seg", 32'(seg), 32'b0110000);

        // Code sweep on digit 0
        for (int c = 0; c < 16; c++) begin
            wait_fs();
            digits_in[3:0] = 4'(c);
            wait_fs();
            @(negedge clk);
            if (c == 10) chk("code10_dash", 32'(seg), 32'b0000001);
            if (c == 11) chk("code11_blank", 32'(seg), 32'd0);
            if (c == 14) chk("code14_blank", 32'(seg), 32'd0);
            if (c == 15) chk("code15_blank", 32'(seg), 32'd0);
            if (c == 12) chk("code12_A", 32'(seg), 32'b1110111);
        end

        // Mid-frame change on digit 0
        wait_fs();
        digits_in[3:0] = 4'd5;
        wait_fs();
        @(negedge clk);
        chk("pre_change", 32'(seg), 32'b1011011);
        repeat (9) @(negedge clk);
        digits_in[3:0] = 4'd7;
        wait_fs();
        @(negedge clk);
        chk("post_change", 32'(seg), 32'b1110000);

        // Leading-zero blanking on digit 5
        for (int t = 0; t < 3; t++) begin
            wait_fs();
            digits_in[23:20] = (t == 2) ? 4'd1 : 4'd0;
            blank_lz = (t != 1);
            wait_fs();
            repeat (21) @(negedge clk);
            chk("lz_en", 32'(dig_en), 32'b100000);
            chk("lz_seg", 32'(seg), (t == 0) ? 32'd0 : (t == 1) ? 32'b1111110 : 32'b0110000);
        end
        blank_lz = 1'b0;

        // Asynchronous reset during idx 3, then blink from a clean start
        wait_fs();
        repeat (13) @(negedge clk);
        chk("pre_rst_en", 32'(dig_en), 32'b001000);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_seg", 32'(seg), 32'd0);
        chk("async_rst_en", 32'(dig_en), 32'd0);
        digits_in  = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        blink_mask = 6'b000011;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_fs", 32'(frame_start), 32'd1);
        @(negedge clk);
        chk("blink_f0_seg", 32'(seg), 32'b1011111);
        repeat (48) @(negedge clk);
        chk("blink_f2_en", 32'(dig_en), 32'b000001);
        chk("blink_f2_seg", 32'(seg), 32'd0);
        repeat (8) @(negedge clk);
        chk("blink_f2_d2_en", 32'(dig_en), 32'b000100);
        chk("blink_f2_d2_seg", 32'(seg), 32'b0110011);
        repeat (40) @(negedge clk);
        chk("blink_f4_seg", 32'(seg), 32'b1011111);

        // Randomized inputs changing at arbitrary points in the frame
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                digits_in = 24'($urandom);
                if ($urandom_range(0, 2) == 0) digits_in[23:20] = 4'd0;
            end
            if ($urandom_range(0, 40) == 0) blink_mask = 6'($urandom);
            if ($urandom_range(0, 30) == 0) blank_lz = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
